// File: rtl/stream_mux_nx1.sv
// stream_mux_nx1: N-input to 1-output stream multiplexer with a registered
// output stage. Channel selection is either fixed (by s) or round-robin
// starting from an internal pointer that advances past each accepted channel.
module stream_mux_nx1 #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N*W-1:0]           in_data,
    input  logic [N-1:0]             in_valid,
    output logic [N-1:0]             in_ready,
    input  logic [$clog2(N)-1:0]     s,
    input  logic                     rr_en,
    output logic [W-1:0]             out_data,
    output logic [$clog2(N)-1:0]     out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int unsigned SW = $clog2(N);
    // Channel count held one bit wider than the index so it compares cleanly.
    localparam logic [SW:0] NW = (SW+1)'(N);
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    logic [N-1:0][W-1:0] ch_data;
    logic [SW-1:0]       ptr;
    logic                load_ok;
    logic                grant_any;
    logic [SW-1:0]       grant_idx;
    logic [SW:0]         cand;

    assign ch_data = in_data;
    assign load_ok = !out_valid || out_ready;

    // Grant decision: fixed select, or first valid channel upward from ptr with wrap.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (rr_en) begin
            for (int unsigned k = 0; k < N; k++) begin
                cand = {1'b0, ptr} + (SW+1)'(k);
                if (cand >= NW) begin
                    cand = cand - NW;
                end
                if (!grant_any && in_valid[cand[SW-1:0]]) begin
                    grant_any = 1'b1;
                    grant_idx = cand[SW-1:0];
                end
            end
        end else if ({1'b0, s} < NW) begin
            if (in_valid[s]) begin
                grant_any = 1'b1;
                grant_idx = s;
            end
        end
    end

    // One-hot accept strobe; suppressed during reset and while the output is stalled.
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            in_ready[i] = !rst && load_ok && grant_any && (grant_idx == SW'(i));
        end
    end

    // Output register and round-robin pointer; both advance only on a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load_ok) begin
            out_valid <= grant_any;
            if (grant_any) begin
                out_data <= ch_data[grant_idx];
                out_ch   <= grant_idx;
                ptr      <= (grant_idx == LAST) ? '0 : grant_idx + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Self-checking bench for stream_mux_nx1: directed scenarios plus randomized
// traffic compared against a behavioural model of the mux.
module tb_stream_mux_nx1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] in_data = '0;
    logic [15:0]  in_valid = '0;
    logic [15:0]  in_ready;
    logic [3:0]   s = '0;
    logic         rr_en = 1'b0;
    logic [7:0]   out_data;
    logic [3:0]   out_ch;
    logic         out_valid;
    logic         out_ready = 1'b1;

    // Second instance with a non-power-of-two channel count.
    logic [79:0]  in_data10 = '0;
    logic [9:0]   in_valid10 = '0;
    logic [9:0]   in_ready10;
    logic [3:0]   s10 = '0;
    logic [7:0]   out_data10;
    logic [3:0]   out_ch10;
    logic         out_valid10;

    int total = 0;
    int bad = 0;

    // Behavioural model state
    int         m_ptr = 0;
    bit         m_valid = 1'b0;
    logic [7:0] m_data = '0;
    int         m_ch = 0;

    stream_mux_nx1 #(.N(16), .W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .s(s), .rr_en(rr_en), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_mux_nx1 #(.N(10), .W(8)) dut10 (
        .clk(clk), .rst(rst), .in_data(in_data10), .in_valid(in_valid10),
        .in_ready(in_ready10), .s(s10), .rr_en(1'b0), .out_data(out_data10),
        .out_ch(out_ch10), .out_valid(out_valid10), .out_ready(1'b1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Which channel the rules grant, or -1 for none.
    function automatic int pick(input logic [15:0] v, input bit rr, input int sel, input int p);
        int c;
        if (!rr) begin
            if (sel < 16 && v[sel[3:0]]) return sel;
            return -1;
        end
        for (int k = 0; k < 16; k++) begin
            c = (p + k) % 16;
            if (v[c[3:0]]) return c;
        end
        return -1;
    endfunction

    // One clock: check DUT against model mid-cycle, then advance the model across the edge.
    task automatic cycle();
        int         g;
        bit         lok;
        logic [15:0] exp_rdy;
        logic [7:0] d;
        @(negedge clk);
        lok = !m_valid || out_ready;
        g = pick(in_valid, rr_en, int'(s), m_ptr);
        exp_rdy = '0;
        if (!rst && lok && g >= 0) exp_rdy[g[3:0]] = 1'b1;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_data", 64'(out_data), 64'(m_data));
        check("out_ch", 64'(out_ch), 64'(m_ch));
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
        end else if (lok) begin
            m_valid = (g >= 0);
            if (g >= 0) begin
                d = in_data[g*8 +: 8];
                m_data = d;
                m_ch = g;
                m_ptr = (g + 1) % 16;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = 8'($urandom);
    endtask

    logic [7:0] held_data;
    logic [3:0] held_ch;

    initial begin
        // Reset
        rand_data();
        cycle();
        rst = 1'b0;

        // N=10: load channel 3, then an out-of-range select grants nothing
        in_valid10 = '1;
        s10 = 4'd3;
        in_data10[3*8 +: 8] = 8'h3C;
        cycle();
        check("n10_load_valid", 64'(out_valid10), 64'd1);
        check("n10_load_ch", 64'(out_ch10), 64'd3);
        check("n10_load_data", 64'(out_data10), 64'h3C);
        s10 = 4'd12;
        #1;
        check("n10_s12_ready", 64'(in_ready10), 64'd0);
        cycle();
        check("n10_s12_valid", 64'(out_valid10), 64'd0);
        check("n10_s12_ch_hold", 64'(out_ch10), 64'd3);
        check("n10_s12_ready2", 64'(in_ready10), 64'd0);

        // Fixed select of channel 5
        rst = 1'b1; cycle(); rst = 1'b0;
        rr_en = 1'b0; s = 4'd5; in_valid = 16'h0020; out_ready = 1'b1;
        in_data[5*8 +: 8] = 8'hA5;
        #1;
        check("fix5_ready", 64'(in_ready), 64'h0020);
        cycle();
        check("fix5_data", 64'(out_data), 64'hA5);
        check("fix5_ch", 64'(out_ch), 64'd5);
        check("fix5_valid", 64'(out_valid), 64'd1);

        // Round-robin sweep from channel 0 with every channel valid
        rst = 1'b1; cycle(); rst = 1'b0;
        rr_en = 1'b1; in_valid = 16'hFFFF;
        for (int i = 0; i < 18; i++) begin
            rand_data();
            cycle();
            check("rr_sweep_ch", 64'(out_ch), 64'(i % 16));
            check("rr_sweep_valid", 64'(out_valid), 64'd1);
        end

        // Wrap: ptr=1 with channels 0 and 15 valid
        rst = 1'b1; cycle(); rst = 1'b0;
        rr_en = 1'b0; s = 4'd0; in_valid = 16'h0001; cycle();
        rr_en = 1'b1; in_valid = 16'h8001;
        cycle(); check("wrap_1", 64'(out_ch), 64'd15);
        cycle(); check("wrap_2", 64'(out_ch), 64'd0);
        cycle(); check("wrap_3", 64'(out_ch), 64'd15);

        // Backpressure hold for 3 cycles, then release
        out_ready = 1'b0;
        held_data = out_data;
        held_ch = out_ch;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            cycle();
            check("hold_data", 64'(out_data), 64'(held_data));
            check("hold_ch", 64'(out_ch), 64'(held_ch));
            check("hold_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        cycle();
        check("release_ch", 64'(out_ch), 64'd0);
        check("release_valid", 64'(out_valid), 64'd1);

        // Reset mid-stream with ptr=7 and a held beat
        rr_en = 1'b0; s = 4'd6; in_valid = 16'h0040; cycle();
        out_ready = 1'b0; rst = 1'b1; cycle();
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_ch", 64'(out_ch), 64'd0);
        rst = 1'b0; out_ready = 1'b1; rr_en = 1'b1; in_valid = 16'h0C08;
        cycle();
        check("midrst_first_rr", 64'(out_ch), 64'd3);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rand_data();
            in_valid  = 16'($urandom) & 16'($urandom);
            s         = 4'($urandom);
            rr_en     = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_mux_nx1.md
STREAM_MUX_NX1 -- requirements
Module: stream_mux_nx1

Interface
REQ-001 SHALL have parameter N, default 16, meaning number of input channels, legal range 2..16.
REQ-002 SHALL have parameter W, default 8, meaning data width per channel, legal range 1..64.
REQ-003 SHALL define SW = clog2(N), the select and channel-ID width.
REQ-004 SHALL have port clk  input  1  single clock, rising-edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  N*W  channel i occupies bits [i*W+W-1 : i*W].
REQ-007 SHALL have port in_valid  input  N  per-channel beat available.
REQ-008 SHALL have port in_ready  output  N  per-channel beat accepted this cycle.
REQ-009 SHALL have port s  input  SW  fixed-mode channel select.
REQ-010 SHALL have port rr_en  input  1  0 = fixed select by s, 1 = round-robin across channels.
REQ-011 SHALL have port out_data  output  W  registered selected beat.
REQ-012 SHALL have port out_ch  output  SW  channel index of the beat on out_data.
REQ-013 SHALL have port out_valid  output  1  out_data/out_ch hold a beat.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the beat.

Function
REQ-015 SHALL compute load_ok = !out_valid || out_ready, combinationally.
REQ-016 In fixed mode (rr_en=0), SHALL grant channel s when in_valid[s]=1 and s<N; otherwise SHALL grant no channel.
REQ-017 In round-robin mode (rr_en=1), SHALL grant the first channel with in_valid=1, searching upward from ptr and wrapping N-1 -> 0.
REQ-018 SHALL drive in_ready[g]=1 only when load_ok=1 and channel g is granted; all other in_ready bits SHALL be 0, and at most one bit SHALL be high per cycle.
REQ-019 On a transfer (in_valid[g] && in_ready[g]), SHALL load out_data <= channel g data, out_ch <= g and out_valid <= 1 at the next edge, giving 1-cycle latency.
REQ-020 When load_ok=1 and no channel is granted, SHALL set out_valid <= 0; out_data and out_ch SHALL hold their previous values.
REQ-021 When out_valid=1 and out_ready=0, SHALL hold out_data, out_ch and out_valid stable, and in_ready SHALL be all 0.
REQ-022 When out_ready=1 and a grant occur in the same cycle, SHALL replace the beat without a bubble, sustaining 1 beat/cycle.
REQ-023 SHALL update the internal pointer ptr (SW bits) only on a transfer: ptr <= g+1, wrapping to 0 when g=N-1. This applies in both modes.
REQ-024 A change of rr_en or s SHALL take effect on the next grant decision; it SHALL NOT reset ptr or disturb a held beat.
REQ-025 in_ready SHALL depend on out_valid, out_ready, in_valid, s, rr_en and ptr only, and SHALL NOT depend on in_data.

Reset
REQ-026 While rst=1 at a clk edge, SHALL set out_valid=0, out_data=0, out_ch=0 and ptr=0.
REQ-027 While rst=1, SHALL force in_ready to all 0, and no transfer SHALL occur in that cycle.
REQ-028 Reset asserted mid-stream SHALL discard any held beat; the first grant after reset SHALL start the round-robin search at channel 0.

Verification (N=16, W=8 unless stated)
REQ-029 SHALL cover: rst 1 cycle, then rr_en=0, s=5, in_valid=16'h0020, d5=8'hA5, out_ready=1 -> in_ready=16'h0020, and out_data=A5, out_ch=5, out_valid=1 one cycle later.
REQ-030 SHALL cover: rr_en=1, in_valid=16'hFFFF held, out_ready=1 for 18 cycles -> out_ch sequence 0,1,...,15,0,1 with no bubbles.
REQ-031 SHALL cover: rr_en=1, in_valid=16'h8001, ptr=1 -> grant 15, then 0 (wrap), then 15.
REQ-032 SHALL cover: out_valid=1 with out_ready=0 for 3 cycles -> out_data/out_ch stable and in_ready=0, then out_ready=1 -> next beat loads the following cycle.
REQ-033 SHALL cover: N=10, rr_en=0, s=12, in_valid=all ones -> no grant, in_ready=0, out_valid falls to 0.
REQ-034 SHALL cover: rst asserted while out_valid=1 and ptr=7 -> next cycle out_valid=0, out_ch=0, and the first round-robin grant after reset is the lowest valid channel from 0.
